uart_cmd_parser: RTL



---
 rtl/uart_pkg.sv | 31 +++
 rtl/uart_gap_timer.sv | 31 +++
 rtl/uart_cmd_parser.sv | 124 ++++++++++++
 3 files changed

// File: rtl/uart_pkg.sv
// Shared UART definitions: parser state encoding, command payload and baud/timeout arithmetic.
package uart_pkg;

    typedef enum logic [2:0] {
        IDLE,
        OPADDR,
        DHI,
        DLO,
        CSUM
    } state_t;

    localparam logic [7:0] DEFAULT_SYNC_BYTE = 8'hA5;

    typedef struct packed {
        logic        write;
        logic [6:0]  addr;
        logic [15:0] wdata;
    } cmd_t;

    function automatic int unsigned calc_period(input int unsigned clk_freq,
                                                input int unsigned baud);
        return clk_freq / baud;
    endfunction

    function automatic int unsigned calc_timeout_cyc(input int unsigned clk_freq,
                                                     input int unsigned baud,
                                                     input int unsigned timeout_ui);
        return calc_period(clk_freq, baud) * timeout_ui;
    endfunction

endpackage

// File: rtl/uart_gap_timer.sv
// Inter-byte gap counter; expire pulses when a running gap hits LIMIT-1 without a clearing byte.
module uart_gap_timer #(
    parameter int unsigned LIMIT = 300
) (
    input  logic clk,
    input  logic rst_n,
    input  logic run,
    input  logic clear,
    output logic expire
);

    localparam int unsigned CNT_W = (LIMIT > 1) ? $clog2(LIMIT) : 1;

    logic [CNT_W-1:0] count;
    logic             terminal;

    assign terminal = (count == CNT_W'(LIMIT - 1));
    // A byte arriving on the terminal cycle takes priority over expiry.
    assign expire   = run && !clear && terminal;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            count <= '0;
        end else if (clear || !run || terminal) begin
            count <= '0;
        end else begin
            count <= count + CNT_W'(1);
        end
    end

endmodule

// File: rtl/uart_cmd_parser.sv
// Assembles SYNC/OPADDR/DHI/DLO/CSUM frames from received bytes into register-access commands.
module uart_cmd_parser
    import uart_pkg::*;
#(
    parameter int unsigned CLK_FREQ   = 50000000,
    parameter int unsigned UART_BPS   = 9600,
    parameter logic [7:0]  SYNC_BYTE  = DEFAULT_SYNC_BYTE,
    parameter int unsigned TIMEOUT_UI = 30
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        uart_rx_done,
    input  logic [7:0]  data,
    output logic        cmd_valid,
    output logic        cmd_write,
    output logic [6:0]  cmd_addr,
    output logic [15:0] cmd_wdata,
    output logic        err_checksum,
    output logic        err_timeout,
    output logic        busy
);

    localparam int unsigned TIMEOUT_CYC = calc_timeout_cyc(CLK_FREQ, UART_BPS, TIMEOUT_UI);

    state_t     state, state_nxt;
    logic [7:0] csum_acc, csum_nxt;
    cmd_t       shadow, shadow_nxt;
    cmd_t       cmd_q, cmd_nxt;
    logic       valid_nxt, errc_nxt, errt_nxt, busy_nxt;
    logic       expire;

    uart_gap_timer #(
        .LIMIT (TIMEOUT_CYC)
    ) u_gap_timer (
        .clk    (clk),
        .rst_n  (rst_n),
        .run    (state != IDLE),
        .clear  (uart_rx_done),
        .expire (expire)
    );

    // Next-state, shadow capture and running checksum.
    always_comb begin
        state_nxt  = state;
        csum_nxt   = csum_acc;
        shadow_nxt = shadow;
        cmd_nxt    = cmd_q;
        valid_nxt  = 1'b0;
        errc_nxt   = 1'b0;
        errt_nxt   = 1'b0;
        if (uart_rx_done) begin
            case (state)
                IDLE: begin
                    if (data == SYNC_BYTE) begin
                        state_nxt = OPADDR;
                        csum_nxt  = '0;
                    end
                end
                OPADDR: begin
                    shadow_nxt.write = data[7];
                    shadow_nxt.addr  = data[6:0];
                    csum_nxt         = csum_acc ^ data;
                    state_nxt        = DHI;
                end
                DHI: begin
                    shadow_nxt.wdata[15:8] = data;
                    csum_nxt               = csum_acc ^ data;
                    state_nxt              = DLO;
                end
                DLO: begin
                    shadow_nxt.wdata[7:0] = data;
                    csum_nxt              = csum_acc ^ data;
                    state_nxt             = CSUM;
                end
                CSUM: begin
                    if (data == csum_acc) begin
                        cmd_nxt   = shadow;
                        valid_nxt = 1'b1;
                    end else begin
                        errc_nxt  = 1'b1;
                    end
                    csum_nxt  = '0;
                    state_nxt = IDLE;
                end
                default: begin
                    csum_nxt  = '0;
                    state_nxt = IDLE;
                end
            endcase
        end else if (expire) begin
            state_nxt = IDLE;
            csum_nxt  = '0;
            errt_nxt  = 1'b1;
        end
        busy_nxt = (state_nxt != IDLE);
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state        <= IDLE;
            csum_acc     <= '0;
            shadow       <= '0;
            cmd_q        <= '0;
            cmd_valid    <= 1'b0;
            err_checksum <= 1'b0;
            err_timeout  <= 1'b0;
            busy         <= 1'b0;
        end else begin
            state        <= state_nxt;
            csum_acc     <= csum_nxt;
            shadow       <= shadow_nxt;
            cmd_q        <= cmd_nxt;
            cmd_valid    <= valid_nxt;
            err_checksum <= errc_nxt;
            err_timeout  <= errt_nxt;
            busy         <= busy_nxt;
        end
    end

    assign cmd_write = cmd_q.write;
    assign cmd_addr  = cmd_q.addr;
    assign cmd_wdata = cmd_q.wdata;

endmodule
